// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver with a two-flop synchroniser, deframing FSM and a small
// receive FIFO presented as an AXI-Stream byte master.
module uart_rx_axis #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_rx,
    output logic [7:0]                    m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          o_frame_err,
    output logic                          o_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int AW           = $clog2(FIFO_DEPTH);

    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("uart_rx_axis: CLK_FREQ/BAUD must be >= 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_axis: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

    state_t          state, state_d;
    logic            rx_meta, rx_s;
    logic [CW-1:0]   cnt, cnt_d;
    logic [2:0]      idx, idx_d;
    logic [7:0]      shreg, shreg_d;
    logic            push, ferr_d;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            empty, full, pop, wr_en, ovf;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= WAIT_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            idx         <= idx_d;
            shreg       <= shreg_d;
            o_frame_err <= ferr_d;
        end
    end

    // Counter counts down to zero; a load of N-1 means the sample lands N cycles later.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        shreg_d = shreg;
        push    = 1'b0;
        ferr_d  = 1'b0;
        case (state)
            WAIT_IDLE: if (rx_s) state_d = IDLE;
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = CW'(HALF_BIT - 1);
                    state_d = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (!rx_s) begin
                        cnt_d   = CW'(CLKS_PER_BIT - 1);
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shreg_d[idx] = rx_s;
                    cnt_d        = CW'(CLKS_PER_BIT - 1);
                    if (idx == 3'd7) state_d = STOP;
                    else             idx_d   = idx + 3'd1;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = m_axis_tvalid && m_axis_tready;
    assign wr_en = push && (!full || pop);
    assign ovf   = push && full && !pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            o_overrun <= ovf;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign o_fifo_level  = wr_ptr - rd_ptr;

endmodule
